// File: rtl/sll_access_arbiter_pkg.sv
// Opcode encodings, opcode classification helpers and the FSM state type shared by the
// list arbiter and the code that talks to the singly linked list.
package sll_access_arbiter_pkg;

    localparam logic [2:0] OP_READ     = 3'b000;
    localparam logic [2:0] OP_INS_ADDR = 3'b001;
    localparam logic [2:0] OP_INS_IDX  = 3'b101;
    localparam logic [2:0] OP_DEL_VAL  = 3'b010;
    localparam logic [2:0] OP_DEL_ADDR = 3'b011;
    localparam logic [2:0] OP_DEL_IDX  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        REJ,
        RESP
    } state_t;

    function automatic logic is_insert(input logic [2:0] op);
        return (op == OP_INS_ADDR) || (op == OP_INS_IDX);
    endfunction

    function automatic logic is_delete(input logic [2:0] op);
        return (op == OP_DEL_VAL) || (op == OP_DEL_ADDR) || (op == OP_DEL_IDX);
    endfunction

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == OP_READ) || is_insert(op) || is_delete(op);
    endfunction

endpackage

// File: rtl/sll_access_arbiter_if.sv
// Bundle of requester-side and list-side signals around the list arbiter.
// The slave modport is the arbiter's view; the master modport is its environment.
interface sll_access_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [3*NUM_REQ-1:0]          req_op;
    logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr;
    logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [ADDR_WIDTH-1:0]         rsp_next_addr;
    logic                          rsp_fault;
    logic                          timeout_err;
    logic [2:0]                    ll_op;
    logic [ADDR_WIDTH-1:0]         ll_addr_in;
    logic [DATA_WIDTH-1:0]         ll_data_in;
    logic                          ll_op_start;
    logic [DATA_WIDTH-1:0]         ll_data_out;
    logic [ADDR_WIDTH-1:0]         ll_next_addr;
    logic                          ll_op_done;
    logic                          ll_fault;
    logic                          ll_full;
    logic                          ll_empty;

    modport master (
        output req_valid, req_op, req_addr, req_data,
        output ll_data_out, ll_next_addr, ll_op_done, ll_fault, ll_full, ll_empty,
        input  req_ready, rsp_valid, rsp_data, rsp_next_addr, rsp_fault, timeout_err,
        input  ll_op, ll_addr_in, ll_data_in, ll_op_start
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data,
        input  ll_data_out, ll_next_addr, ll_op_done, ll_fault, ll_full, ll_empty,
        output req_ready, rsp_valid, rsp_data, rsp_next_addr, rsp_fault, timeout_err,
        output ll_op, ll_addr_in, ll_data_in, ll_op_start
    );

endinterface

// File: rtl/sll_access_arbiter_rr.sv
// Combinational round-robin picker: the first active request after the last grant wins.
module sll_access_arbiter_rr #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_id_o
);
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(last_i) + k) % N);
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                grant_o     = '0;
                grant_o[idx] = 1'b1;
                grant_id_o  = idx;
            end
        end
    end

endmodule

// File: rtl/sll_access_arbiter.sv
// Serialises NUM_REQ requesters onto one singly linked list, one operation at a time.
// Illegal or impossible requests are answered locally; a watchdog aborts hung list operations.
module sll_access_arbiter
    import sll_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_NODE    = 8,
    parameter int ADDR_WIDTH  = $clog2(MAX_NODE + 1),
    parameter int TIMEOUT_CYC = 256
) (
    input logic                 clk,
    input logic                 rst,
    sll_access_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    state_t                state_q;
    logic [IDW-1:0]        ptr_q;
    logic [IDW-1:0]        id_q;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [WDW-1:0]        wd_q;
    logic                  op_start_q;
    logic                  timeout_q;
    logic                  rsp_fault_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [ADDR_WIDTH-1:0] rsp_next_q;

    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        grant_id;
    logic [2:0]            sel_op_d;
    logic [ADDR_WIDTH-1:0] sel_addr_d;
    logic [DATA_WIDTH-1:0] sel_data_d;
    logic                  reject_d;

    sll_access_arbiter_rr #(.N(NUM_REQ), .IDW(IDW)) u_rr (
        .req_i      (bus.req_valid),
        .last_i     (ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    // Requests the list could never complete are answered without touching it.
    always_comb begin
        sel_op_d   = bus.req_op[int'(grant_id)*3 +: 3];
        sel_addr_d = bus.req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_d = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        reject_d   = !is_valid_op(sel_op_d)
                   || (is_insert(sel_op_d) && bus.ll_full)
                   || (is_delete(sel_op_d) && bus.ll_empty);
    end

    assign bus.req_ready     = (state_q == IDLE) ? grant : '0;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_next_addr = rsp_next_q;
    assign bus.rsp_fault     = rsp_fault_q;
    assign bus.timeout_err   = timeout_q;
    assign bus.ll_op         = op_q;
    assign bus.ll_addr_in    = addr_q;
    assign bus.ll_data_in    = data_q;
    assign bus.ll_op_start   = op_start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NUM_REQ - 1);
            id_q        <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wd_q        <= '0;
            op_start_q  <= 1'b0;
            timeout_q   <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_next_q  <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        op_q   <= sel_op_d;
                        addr_q <= sel_addr_d;
                        data_q <= sel_data_d;
                        id_q   <= grant_id;
                        ptr_q  <= grant_id;
                        wd_q   <= '0;
                        if (reject_d) begin
                            rsp_fault_q <= 1'b1;
                            state_q     <= REJ;
                        end else begin
                            op_start_q <= 1'b1;
                            state_q    <= BUSY;
                        end
                    end
                end
                // The watchdog allows exactly TIMEOUT_CYC cycles of op_start before aborting.
                BUSY: begin
                    if (bus.ll_op_done) begin
                        op_start_q        <= 1'b0;
                        rsp_data_q        <= bus.ll_data_out;
                        rsp_next_q        <= bus.ll_next_addr;
                        rsp_fault_q       <= bus.ll_fault;
                        rsp_valid_q[id_q] <= 1'b1;
                        state_q           <= RESP;
                    end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
                        op_start_q        <= 1'b0;
                        rsp_fault_q       <= 1'b1;
                        timeout_q         <= 1'b1;
                        rsp_valid_q[id_q] <= 1'b1;
                        state_q           <= RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                REJ: begin
                    rsp_fault_q       <= 1'b1;
                    rsp_valid_q[id_q] <= 1'b1;
                    state_q           <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sll_access_arbiter.sv
// Randomised bench: requesters and a behavioural list stand-in drive the arbiter while a
// scoreboard checks grant order, list handshakes and every response against a reference model.
module tb_sll_access_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        int         id;
        logic [2:0] op;
        logic [3:0] addr;
        logic [7:0] data;
        bit         rej;
        bit         hang;
        int         delay;
        logic [7:0] rdata;
        logic [3:0] rnext;
        bit         rfault;
    } txn_t;

    logic clk;
    logic rst;
    int   checks       = 0;
    int   failures     = 0;
    int   txCount      = 0;
    int   lastGrant    = NREQ - 1;
    bit   inFlight     = 0;
    bit   rspPulse     = 0;
    bit   stopStim     = 0;
    bit   forceHang    = 0;
    bit   forcedIssued = 0;
    bit   timeoutModel = 0;
    txn_t scoreQ[$];
    txn_t listQ[$];

    sll_access_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sll_access_arbiter #(
        .NUM_REQ     (NREQ),
        .DATA_WIDTH  (DW),
        .MAX_NODE    (8),
        .ADDR_WIDTH  (AW),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int rrModel(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit isRejected(input logic [2:0] op, input logic full, input logic empty);
        case (op)
            3'b000:                 return 1'b0;
            3'b001, 3'b101:         return full;
            3'b010, 3'b011, 3'b111: return empty;
            default:                return 1'b1;
        endcase
    endfunction

    // One cycle: check readiness against the fairness model, log any transfer, then update inputs.
    task automatic applyStimulus();
        int         win;
        logic [3:0] expReady;
        txn_t       t;
        @(negedge clk);
        #1;
        win      = -1;
        expReady = '0;
        if (inFlight) begin
            if (rspPulse) begin
                inFlight = 0;
                rspPulse = 0;
            end
        end else begin
            win = rrModel(bus.req_valid, lastGrant);
            if (win >= 0) expReady[win] = 1'b1;
        end
        checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
        if (win >= 0) begin
            t.id     = win;
            t.op     = bus.req_op[win*3 +: 3];
            t.addr   = bus.req_addr[win*AW +: AW];
            t.data   = bus.req_data[win*DW +: DW];
            t.rej    = isRejected(t.op, bus.ll_full, bus.ll_empty);
            t.hang   = !t.rej && (forceHang || ($urandom_range(0, 19) == 0));
            t.delay  = $urandom_range(1, 6);
            t.rdata  = 8'($urandom);
            t.rnext  = 4'($urandom);
            t.rfault = ($urandom_range(0, 7) == 0);
            if (t.hang && forceHang) begin
                forceHang    = 0;
                forcedIssued = 1;
            end
            scoreQ.push_back(t);
            if (!t.rej) listQ.push_back(t);
            lastGrant = win;
            inFlight  = 1;
            txCount++;
        end
        @(posedge clk);
        #1;
        if (win >= 0) bus.req_valid[win] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i] && !stopStim && i != win && $urandom_range(0, 2) == 0) begin
                bus.req_valid[i]         = 1'b1;
                bus.req_op[i*3 +: 3]     = 3'($urandom_range(0, 7));
                bus.req_addr[i*AW +: AW] = 4'($urandom);
                bus.req_data[i*DW +: DW] = 8'($urandom);
            end
        end
        case ($urandom_range(0, 9))
            0:       begin bus.ll_full = 1'b1; bus.ll_empty = 1'b0; end
            1:       begin bus.ll_full = 1'b0; bus.ll_empty = 1'b1; end
            default: begin bus.ll_full = 1'b0; bus.ll_empty = 1'b0; end
        endcase
    endtask

    // Behavioural list: accepts each op_start, answers after a random delay or never (hang).
    initial begin : listEmulator
        txn_t cur;
        bit   active;
        bit   arm;
        int   cnt;
        active = 0;
        cnt    = 0;
        bus.ll_op_done   = 1'b0;
        bus.ll_data_out  = '0;
        bus.ll_next_addr = '0;
        bus.ll_fault     = 1'b0;
        forever begin
            @(negedge clk);
            arm = 0;
            if (rst) begin
                active = 0;
            end else begin
                if (bus.ll_op_start && !active) begin
                    if (listQ.size() == 0) begin
                        checkOutput("unexpected_op_start", 32'(bus.ll_op_start), 32'd0);
                        cur.hang  = 0;
                        cur.delay = 1;
                    end else begin
                        cur = listQ.pop_front();
                        checkOutput("ll_op", 32'(bus.ll_op), 32'(cur.op));
                        checkOutput("ll_addr_in", 32'(bus.ll_addr_in), 32'(cur.addr));
                        checkOutput("ll_data_in", 32'(bus.ll_data_in), 32'(cur.data));
                    end
                    active = 1;
                    cnt    = 0;
                end
                if (active) begin
                    if (bus.ll_op_start) begin
                        cnt++;
                        if (!cur.hang && cnt == cur.delay) arm = 1;
                    end else begin
                        if (cur.hang) checkOutput("watchdog_len", 32'(cnt), 32'(TIMEOUT));
                        active = 0;
                    end
                end
            end
            @(posedge clk);
            #1;
            bus.ll_op_done = arm;
            if (arm) begin
                bus.ll_data_out  = cur.rdata;
                bus.ll_next_addr = cur.rnext;
                bus.ll_fault     = cur.rfault;
            end
        end
    end

    initial begin : monitor
        txn_t       e;
        logic [3:0] expValid;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid != '0) begin
                if (scoreQ.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e        = scoreQ.pop_front();
                    expValid = 4'(1 << e.id);
                    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(expValid));
                    if (e.hang) timeoutModel = 1;
                    checkOutput("rsp_fault", 32'(bus.rsp_fault), 32'((e.rej || e.hang) ? 1'b1 : e.rfault));
                    if (!e.rej && !e.hang) begin
                        checkOutput("rsp_data", 32'(bus.rsp_data), 32'(e.rdata));
                        checkOutput("rsp_next_addr", 32'(bus.rsp_next_addr), 32'(e.rnext));
                    end
                    checkOutput("timeout_err", 32'(bus.timeout_err), 32'(timeoutModel));
                end
                rspPulse = 1;
            end
        end
    end

    task automatic drain();
        bit done;
        done     = 0;
        stopStim = 1;
        for (int c = 0; c < 800 && !done; c++) begin
            applyStimulus();
            done = (scoreQ.size() == 0) && !inFlight && (bus.req_valid == '0);
        end
        if (!done) checkOutput("drain_timeout", 32'(scoreQ.size()), 32'd0);
        stopStim = 0;
    endtask

    initial begin : main
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.ll_full   = 1'b0;
        bus.ll_empty  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ll_op_start", 32'(bus.ll_op_start), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
        checkOutput("reset_timeout_err", 32'(bus.timeout_err), 32'd0);
        checkOutput("reset_ll_op", 32'(bus.ll_op), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 4000 && txCount < 150; c++) applyStimulus();
        drain();

        // Park a hung operation in BUSY, then reset underneath it.
        forceHang = 1;
        for (int c = 0; c < 500 && !forcedIssued; c++) applyStimulus();
        checkOutput("forced_hang_issued", 32'(forcedIssued), 32'd1);
        repeat (4) applyStimulus();
        checkOutput("busy_before_reset", 32'(bus.ll_op_start), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_drops_op_start", 32'(bus.ll_op_start), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_clears_timeout", 32'(bus.timeout_err), 32'd0);
        scoreQ.delete();
        listQ.delete();
        inFlight     = 0;
        rspPulse     = 0;
        lastGrant    = NREQ - 1;
        timeoutModel = 0;
        forceHang    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]         = 1'b1;
            bus.req_op[i*3 +: 3]     = 3'b000;
            bus.req_addr[i*AW +: AW] = 4'(i);
            bus.req_data[i*DW +: DW] = 8'(10 + i);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
